// File: rtl/uart2b_host.sv
// Half-duplex UART host: sends a 16-bit request as two 8N1 frames,
// then waits for and receives a 16-bit response as two 8N1 frames.
module uart2b_host #(
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [15:0] req_data,
  input  logic        rx,
  output logic        tx,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        frame_err,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10,
    RECV = 2'b11
  } state_t;

  localparam logic [7:0] TO_LIM = TIMEOUT_TICKS[7:0];

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] rsp_q, rsp_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic        fe_q, fe_d;

  logic [7:0]  cur_byte;
  logic [4:0]  pos;
  logic [2:0]  pm1;
  logic        send_bit;
  logic [7:0]  cnt_inc;

  // Bit position 0..19 -> start / data LSB first / stop, high byte first.
  always_comb begin
    cur_byte = (bit_q < 5'd10) ? word_q[15:8] : word_q[7:0];
    pos      = (bit_q < 5'd10) ? bit_q : bit_q - 5'd10;
    pm1      = 3'(pos - 5'd1);
    if (pos == 5'd0)      send_bit = 1'b0;
    else if (pos == 5'd9) send_bit = 1'b1;
    else                  send_bit = cur_byte[pm1];
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hi_d    = hi_q;
    rsp_d   = rsp_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          word_d  = req_data;
          bit_d   = 5'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          if (bit_q == 5'd20) begin
            tx_d    = 1'b1;
            idx_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = WAIT;
          end else begin
            tx_d  = send_bit;
            bit_d = bit_q + 5'd1;
          end
        end
      end
      WAIT: begin
        tx_d = 1'b1;
        if (tick) begin
          if (!rx) begin
            cnt_d   = 8'd0;
            bit_d   = 5'd0;
            state_d = RECV;
          end else if (cnt_inc == TO_LIM) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RECV: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_q != 5'd8) begin
            shift_d = {rx, shift_q[7:1]};
            bit_d   = bit_q + 5'd1;
          end else if (!rx) begin
            fe_d    = 1'b1;
            state_d = IDLE;
          end else if (!idx_q) begin
            hi_d    = shift_q;
            idx_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = WAIT;
          end else begin
            rsp_d   = {hi_q, shift_q};
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= 1'b0;
      shift_q <= '0;
      hi_q    <= '0;
      rsp_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hi_q    <= hi_d;
      rsp_q   <= rsp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      fe_q    <= fe_d;
    end
  end

  assign tx        = tx_q;
  assign rsp_data  = rsp_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = to_q;
  assign frame_err = fe_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_uart2b_host.sv
// Directed + randomized bench for uart2b_host with a frame-level
// reference model of the request and response serial streams.
module tb_uart2b_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        start;
  logic [15:0] req_data;
  logic        rx;
  logic        tx;
  logic [15:0] rsp_data;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        frame_err;
  logic [1:0]  state_out;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_rsp;

  uart2b_host #(.TIMEOUT_TICKS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .req_data  (req_data),
    .rx        (rx),
    .tx        (tx),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .frame_err (frame_err),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One bit time: three idle clocks, then a clock with tick high.
  task automatic tk(input logic r);
    rx   = r;
    tick = 1'b0;
    repeat (3) clk1();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  // Expected line level for request bit i (0..19) of word w.
  function automatic logic mbit(input logic [15:0] w, input int i);
    int b, p, by;
    b  = i / 10;
    p  = i % 10;
    by = (b == 0) ? int'(w) / 256 : int'(w) % 256;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return 1'((by >> (p - 1)) & 1);
  endfunction

  task automatic accept(input logic [15:0] w);
    start    = 1'b1;
    req_data = w;
    clk1();
    start    = 1'b0;
    req_data = $urandom();
    chk("acc_state", 32'(state_out), 32'd1);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_tx", 32'(tx), 32'd1);
  endtask

  task automatic send_check(input logic [15:0] w, input bit spoil);
    accept(w);
    for (int i = 0; i < 20; i++) begin
      if (spoil && i == 5) begin
        start    = 1'b1;
        req_data = ~w;
        clk1();
        start    = 1'b0;
      end
      tk(1'b1);
      chk($sformatf("tx_bit%0d", i), 32'(tx), 32'(mbit(w, i)));
    end
    tk(1'b1);
    chk("send_to_wait", 32'(state_out), 32'd2);
    chk("wait_tx", 32'(tx), 32'd1);
  endtask

  task automatic rsp_byte(input logic [7:0] b, input logic stp,
                          input int gap);
    for (int g = 0; g < gap; g++) tk(1'b1);
    tk(1'b0);
    chk("recv_state", 32'(state_out), 32'd3);
    for (int k = 0; k < 8; k++) tk(b[k]);
    tk(stp);
  endtask

  task automatic full_rsp(input logic [15:0] r);
    rsp_byte(r[15:8], 1'b1, int'($urandom_range(0, 10)));
    chk("mid_wait", 32'(state_out), 32'd2);
    chk("mid_nodone", 32'(done), 32'd0);
    rsp_byte(r[7:0], 1'b1, int'($urandom_range(0, 10)));
    exp_rsp = r;
    chk("done_pulse", 32'(done), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_rsp));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_state", 32'(state_out), 32'd0);
    chk("done_excl", 32'({timeout, frame_err}), 32'd0);
  endtask

  initial begin
    logic [15:0] w, r;
    reset    = 1'b1;
    tick     = 1'b1;
    start    = 1'b1;
    req_data = 16'hFFFF;
    rx       = 1'b1;
    exp_rsp  = 16'h0000;
    repeat (3) clk1();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({done, timeout, frame_err}), 32'd0);
    chk("rst_rsp", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    clk1();
    chk("post_rst_idle", 32'(state_out), 32'd0);

    send_check(16'hA55A, 1'b0);
    full_rsp(16'h1234);
    clk1();
    chk("done_one_clk", 32'(done), 32'd0);

    // Start on the clock right after the done pulse.
    for (int t = 0; t < 3; t++) begin
      w = 16'($urandom());
      r = 16'($urandom());
      send_check(w, 1'b0);
      full_rsp(r);
    end

    send_check(16'($urandom()), 1'b0);
    for (int i = 0; i < 63; i++) tk(1'b1);
    chk("to_not_yet", 32'(timeout), 32'd0);
    chk("to_still_wait", 32'(state_out), 32'd2);
    tk(1'b1);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_state", 32'(state_out), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_rsp_kept", 32'(rsp_data), 32'(exp_rsp));
    chk("to_excl", 32'({done, frame_err}), 32'd0);
    clk1();
    chk("to_one_clk", 32'(timeout), 32'd0);

    send_check(16'($urandom()), 1'b0);
    rsp_byte(8'($urandom()), 1'b0, 2);
    chk("fe_pulse", 32'(frame_err), 32'd1);
    chk("fe_nodone", 32'(done), 32'd0);
    chk("fe_rsp_kept", 32'(rsp_data), 32'(exp_rsp));
    chk("fe_state", 32'(state_out), 32'd0);
    clk1();
    chk("fe_one_clk", 32'(frame_err), 32'd0);

    send_check(16'($urandom()), 1'b0);
    rsp_byte(8'h5C, 1'b1, 0);
    rsp_byte(8'hC3, 1'b0, 1);
    chk("fe1_pulse", 32'(frame_err), 32'd1);
    chk("fe1_rsp_kept", 32'(rsp_data), 32'(exp_rsp));

    accept(16'h0000);
    for (int i = 0; i < 8; i++) begin
      tk(1'b1);
      chk($sformatf("pre_rst_bit%0d", i), 32'(tx), 32'(mbit(16'h0000, i)));
    end
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_state", 32'(state_out), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_data), 32'd0);
    exp_rsp = 16'h0000;
    send_check(16'h00FF, 1'b0);
    full_rsp(16'($urandom()));

    w = 16'($urandom());
    send_check(w, 1'b1);
    full_rsp(16'hBEEF);
    repeat (8) clk1();
    chk("single_txn", 32'(state_out), 32'd0);
    chk("single_tx", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
